trng_harvester: RTL and testbench

Parametrised entropy harvester, successor to the single-source TRNG core.
- Samples NUM_CH asynchronous raw entropy sources (ring-oscillator taps or pins) and XOR-combines them.
- Optionally applies von Neumann debiasing, runs a repetition-count health test, and packs bits into WORD_W words.
- Words go into a small show-ahead FIFO drained via a valid/ready handshake; sits between the oscillator bank and the tt_um_* top-level I/O mux.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/trng_fifo.sv | 54 +++++
 rtl/trng_harvester.sv | 152 +++++++++++++++
 tb/tb_trng_harvester.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and default constants for the entropy harvester and its output FIFO.
package trng_pkg;

  typedef enum logic [0:0] {
    DB_FIRST  = 1'b0,
    DB_SECOND = 1'b1
  } db_state_e;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_WORD_W      = 8;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_REP_LIMIT   = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Level counter must represent 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// Show-ahead synchronous FIFO with flush; head word is presented combinationally.
module trng_fifo import trng_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WORD_W,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic [level_w(DEPTH)-1:0]   level_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int unsigned LW = level_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/trng_harvester.sv
// Entropy harvester: synchronise and XOR raw sources, health-test, optionally debias,
// pack into words and queue them for a valid/ready consumer.
module trng_harvester import trng_pkg::*; #(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned REP_LIMIT   = DEF_REP_LIMIT,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                debias_en,
  input  logic [NUM_CH-1:0]                   raw_in,
  input  logic                                clear_fail,
  output logic [WORD_W-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [level_w(FIFO_DEPTH)-1:0]      fifo_level,
  output logic                                health_fail,
  output logic                                overflow
);

  localparam int unsigned CW = $clog2(WORD_W);
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic              s;
  logic              prev_q, prev_d;
  logic [RW-1:0]     rep_q, rep_d, rep_next;
  db_state_e         db_q, db_d;
  logic              store_q, store_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d, word;
  logic              fail_q, fail_d, ovf_q, ovf_d;
  logic              fail_set, clear_asm, emit, ebit, push, pop_acc, ovf_set;
  logic              fifo_full, fifo_empty;

  // Synchronisers free-run regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s       = ^sync_q[SYNC_STAGES-1];
  assign pop_acc = out_ready && !fifo_empty;

  always_comb begin
    // rep_q == 0 means no previous sample since reset, en rise or clear_fail.
    rep_next = RW'(1);
    if (rep_q != '0 && s == prev_q) begin
      rep_next = (rep_q == RW'(REP_LIMIT)) ? rep_q : rep_q + RW'(1);
    end
    fail_set  = en && (rep_next == RW'(REP_LIMIT));
    clear_asm = !en || fail_set || fail_q;

    emit    = 1'b0;
    ebit    = s;
    db_d    = db_q;
    store_d = store_q;
    if (!debias_en) begin
      emit = 1'b1;
      db_d = DB_FIRST;
    end else if (db_q == DB_FIRST) begin
      db_d    = DB_SECOND;
      store_d = s;
    end else begin
      db_d = DB_FIRST;
      emit = (s != store_q);
      ebit = store_q;
    end

    word  = {acc_q[WORD_W-2:0], ebit};
    acc_d = acc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (clear_asm) begin
      db_d    = DB_FIRST;
      store_d = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (emit) begin
      acc_d = word;
      if (cnt_q == CW'(WORD_W - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (!en) begin
      rep_d = '0;
    end else if (clear_fail && !fail_set) begin
      rep_d = '0;
    end else begin
      rep_d = rep_next;
    end
    prev_d = en ? s : prev_q;

    ovf_set = push && fifo_full && !pop_acc;
    fail_d  = fail_set || (fail_q && !clear_fail);
    ovf_d   = ovf_set || (ovf_q && !clear_fail);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      rep_q   <= '0;
      db_q    <= DB_FIRST;
      store_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      rep_q   <= rep_d;
      db_q    <= db_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
    end
  end

  trng_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (fail_set || fail_q),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (out_ready),
    .rdata_o (out_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign health_fail = fail_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Bench for trng_harvester: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_trng_harvester;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned WORD_W      = 8;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned REP_LIMIT   = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              debias_en = 1'b0;
  logic              clear_fail = 1'b0;
  logic              out_ready = 1'b0;
  logic [NUM_CH-1:0] raw_in = '0;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic [LW-1:0]     fifo_level;
  logic              health_fail;
  logic              overflow;

  always #5 clk = ~clk;

  trng_harvester #(
    .NUM_CH      (NUM_CH),
    .WORD_W      (WORD_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .REP_LIMIT   (REP_LIMIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .debias_en   (debias_en),
    .raw_in      (raw_in),
    .clear_fail  (clear_fail),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .health_fail (health_fail),
    .overflow    (overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a sample delay line, a run length, a pending pair bit,
  // a list of emitted bits and the FIFO as a queue of words.
  bit m_dl [SYNC_STAGES];
  int m_run;
  bit m_last;
  int m_pair;
  bit m_bits [$];
  int m_fifo [$];
  bit m_fail;
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) m_dl[i] = 1'b0;
    m_run  = 0;
    m_last = 1'b0;
    m_pair = -1;
    m_bits.delete();
    m_fifo.delete();
    m_fail = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    bit s;
    bit new_fail = 1'b0;
    bit pop;
    bit emit = 1'b0;
    bit push = 1'b0;
    bit ovf_set = 1'b0;
    int b = 0;
    int w = 0;
    s = m_dl[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = ^raw_in;
    if (en) begin
      if (m_run > 0 && s == m_last) m_run = (m_run < REP_LIMIT) ? m_run + 1 : m_run;
      else m_run = 1;
      m_last   = s;
      new_fail = (m_run == REP_LIMIT);
      if (clear_fail && !new_fail) m_run = 0;
    end else begin
      m_run = 0;
    end
    pop = (m_fifo.size() > 0) && out_ready;
    if (en && !m_fail && !new_fail) begin
      if (!debias_en) begin
        emit   = 1'b1;
        b      = s;
        m_pair = -1;
      end else if (m_pair < 0) begin
        m_pair = s;
      end else begin
        if (s != m_pair) begin
          emit = 1'b1;
          b    = m_pair;
        end
        m_pair = -1;
      end
      if (emit) begin
        m_bits.push_back(b[0]);
        if (m_bits.size() == WORD_W) begin
          foreach (m_bits[i]) w = (w << 1) | m_bits[i];
          m_bits.delete();
          push = 1'b1;
        end
      end
    end else begin
      m_pair = -1;
      m_bits.delete();
    end
    if (m_fail || new_fail) begin
      m_fifo.delete();
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(w);
        else ovf_set = 1'b1;
      end
    end
    m_fail = new_fail || (m_fail && !clear_fail);
    m_ovf  = ovf_set || (m_ovf && !clear_fail);
  endtask

  task automatic compare();
    int n = m_fifo.size();
    chk("out_valid", out_valid, (n > 0));
    chk("fifo_level", fifo_level, n);
    chk("out_data", out_data, (n > 0) ? m_fifo[0] : 0);
    chk("health_fail", health_fail, m_fail);
    chk("overflow", overflow, m_ovf);
  endtask

  // Single compare process: advance the model at each edge, check shortly after.
  always @(posedge clk) begin
    if (rst_n) begin
      model_step();
      #1;
      compare();
    end
  end

  bit tog = 1'b0;

  task automatic drive(input bit e, input bit d, input logic [NUM_CH-1:0] r, input bit c,
                       input bit rdy);
    @(negedge clk);
    en         = e;
    debias_en  = d;
    raw_in     = r;
    clear_fail = c;
    out_ready  = rdy;
  endtask

  // raw_in[0] toggles every cycle, other channels held low.
  task automatic tog_cycle(input bit e, input bit d, input bit c, input bit rdy);
    tog = ~tog;
    drive(e, d, NUM_CH'(tog), c, rdy);
  endtask

  initial begin
    int fail_edge;
    int mode;
    bit e, dbe, clr, rdy;
    logic [NUM_CH-1:0] r;

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset out_data", out_data, 0);
    chk("reset health_fail", health_fail, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1'b1;

    // Debias off, toggling source: alternating-bit words, overflow on the 5th.
    repeat (4) tog_cycle(0, 0, 0, 0);
    repeat (9) tog_cycle(1, 0, 0, 0);
    chk("A first word level", fifo_level, 1);
    chk("A first word 55/AA", (out_data == 8'h55 || out_data == 8'hAA), 1);
    repeat (24) tog_cycle(1, 0, 0, 0);
    chk("A full level", fifo_level, 4);
    chk("A no overflow yet", overflow, 0);
    repeat (8) tog_cycle(1, 0, 0, 0);
    chk("A overflow level", fifo_level, 4);
    chk("A overflow set", overflow, 1);
    chk("A no health fail", health_fail, 0);
    repeat (4) drive(0, 0, '0, 0, 1);
    chk("A drain level 1", fifo_level, 1);
    drive(0, 0, '0, 0, 1);
    chk("A drained level", fifo_level, 0);
    chk("A drained valid", out_valid, 0);
    chk("A overflow sticky", overflow, 1);
    drive(0, 0, '0, 1, 1);
    drive(0, 0, '0, 0, 0);
    chk("A overflow cleared", overflow, 0);

    // Debias on, same source: one constant word per 16 accepted samples.
    repeat (4) tog_cycle(0, 1, 0, 0);
    repeat (64) tog_cycle(1, 1, 0, 0);
    chk("B level after 63", fifo_level, 3);
    tog_cycle(1, 1, 0, 0);
    chk("B level after 64", fifo_level, 4);
    chk("B word 00/FF", (out_data == 8'h00 || out_data == 8'hFF), 1);
    chk("B no overflow", overflow, 0);
    repeat (6) drive(0, 0, '0, 0, 1);

    // Constant source: failure on the 16th accepted sample, FIFO flushed.
    fail_edge = -1;
    for (int k = 1; k <= 40; k++) begin
      drive(1, 0, '0, 0, 0);
      if (fail_edge < 0 && health_fail) fail_edge = k - 1;
    end
    chk("C fail edge", fail_edge, 16);
    chk("C flushed level", fifo_level, 0);
    chk("C flushed valid", out_valid, 0);
    repeat (3) tog_cycle(0, 0, 0, 0);
    tog_cycle(0, 0, 1, 0);
    repeat (10) tog_cycle(1, 0, 0, 0);
    chk("C fail cleared", health_fail, 0);
    chk("C resumed level", fifo_level, 1);

    // Async reset with 3 words stored and a partial word in progress.
    repeat (12) tog_cycle(0, 0, 0, 1);
    repeat (28) tog_cycle(1, 0, 0, 0);
    chk("D level before reset", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("D reset out_valid", out_valid, 0);
    chk("D reset fifo_level", fifo_level, 0);
    chk("D reset out_data", out_data, 0);
    chk("D reset health_fail", health_fail, 0);
    chk("D reset overflow", overflow, 0);
    model_reset();
    tog_cycle(1, 0, 0, 0);
    rst_n = 1'b1;
    repeat (9) tog_cycle(1, 0, 0, 0);
    chk("D first word level", fifo_level, 1);
    chk("D first word 2A/15", (out_data == 8'h2A || out_data == 8'h15), 1);

    // en dropped after 5 bits: partial bits discarded, FIFO kept.
    repeat (3) tog_cycle(1, 0, 0, 0);
    repeat (3) tog_cycle(0, 0, 0, 0);
    chk("E level kept", fifo_level, 1);
    repeat (8) tog_cycle(1, 0, 0, 0);
    chk("E level after 7", fifo_level, 1);
    tog_cycle(1, 0, 0, 0);
    chk("E level after 8", fifo_level, 2);
    repeat (6) tog_cycle(0, 0, 0, 1);

    // Randomised segments: free random, held constant, toggling.
    dbe = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 2);
      r    = NUM_CH'($urandom);
      if ($urandom_range(0, 1) == 1) dbe = ~dbe;
      for (int c = 0; c < 50; c++) begin
        e = ($urandom_range(0, 19) != 0);
        if (mode == 0) r = NUM_CH'($urandom);
        else if (mode == 2) r = r ^ NUM_CH'(1);
        if ($urandom_range(0, 24) == 0) dbe = ~dbe;
        clr = ($urandom_range(0, 29) == 0);
        rdy = ($urandom_range(0, 2) == 0);
        drive(e, dbe, r, clr, rdy);
      end
    end
    drive(0, 0, '0, 0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
